// File: rtl/umi_crossbar_arbiter_if.sv
// Handshake and select bundle between the UMI crossbar arbiter and its
// neighbours. The slave view belongs to the arbiter. The master view belongs
// to whatever drives the input ports and consumes sel and valid.
interface umi_crossbar_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   umi_in_valid;
  logic [N*N-1:0] umi_in_req;
  logic [N-1:0]   umi_in_ready;
  logic [N*N-1:0] mask;
  logic [N-1:0]   umi_out_valid;
  logic [N-1:0]   umi_out_ready;
  logic [N*N-1:0] sel;

  modport master (
    output umi_in_valid,
    output umi_in_req,
    output mask,
    output umi_out_ready,
    input  umi_in_ready,
    input  umi_out_valid,
    input  sel
  );

  modport slave (
    input  umi_in_valid,
    input  umi_in_req,
    input  mask,
    input  umi_out_ready,
    output umi_in_ready,
    output umi_out_valid,
    output sel
  );
endinterface

// File: rtl/umi_crossbar_arbiter.sv
// Per-output round-robin arbiter that produces the one-hot select matrix for
// an N x N UMI crossbar. Arbitration is combinational. Each output keeps:
//   - a rotating priority pointer, and
//   - a lock that freezes its grant while the downstream stalls an accepted
//     beat.
module umi_crossbar_arbiter #(
  parameter string TARGET = "DEFAULT",
  parameter int    N      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  umi_crossbar_arbiter_if.slave   bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N*N-1:0] filtReq;
  logic [N*N-1:0] ereq;
  logic [N*N-1:0] selC;
  logic [N-1:0]   outValid;
  logic [N-1:0]   inReady;
  logic [N-1:0]   colHit;
  logic [N-1:0]   found;
  logic [PW-1:0]  grantIdx [N];
  logic [PW-1:0]  nextPrio [N];

  logic [PW-1:0]  prio [N];
  logic [N-1:0]   lock;
  logic [N-1:0]   lsel [N];

  // Each input keeps only its lowest-indexed requested output, then valid and
  // the path mask gate it into the effective request.
  always_comb begin
    filtReq = '0;
    colHit  = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!colHit[j] && bus.umi_in_req[i*N+j]) begin
          filtReq[i*N+j] = 1'b1;
          colHit[j]      = 1'b1;
        end
      end
    end
    ereq = filtReq & bus.mask;
    for (int i = 0; i < N; i++) begin
      ereq[i*N +: N] = ereq[i*N +: N] & bus.umi_in_valid;
    end
  end

  // A locked output replays its stored select. Otherwise it grants the first
  // requester at or above its priority pointer, wrapping around.
  always_comb begin
    selC  = '0;
    found = '0;
    for (int i = 0; i < N; i++) begin
      if (lock[i]) begin
        selC[i*N +: N] = lsel[i];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!found[i] && ereq[i*N + ((int'(prio[i]) + k) % N)]) begin
            selC[i*N + ((int'(prio[i]) + k) % N)] = 1'b1;
            found[i] = 1'b1;
          end
        end
      end
    end
  end

  // Valid, ready, the granted index, and the pointer value that follows it.
  always_comb begin
    inReady = '0;
    for (int i = 0; i < N; i++) begin
      outValid[i] = |(selC[i*N +: N] & ereq[i*N +: N]);
      grantIdx[i] = '0;
      for (int j = 0; j < N; j++) begin
        if (selC[i*N+j]) begin
          grantIdx[i] = PW'(j);
        end
        inReady[j] = inReady[j] | (selC[i*N+j] & bus.umi_out_ready[i]);
      end
      nextPrio[i] = (int'(grantIdx[i]) == N-1) ? '0 : grantIdx[i] + 1'b1;
    end
  end

  assign bus.sel           = selC;
  assign bus.umi_out_valid = outValid;
  assign bus.umi_in_ready  = inReady;

  // The handshake result updates each output's state:
  //   - transfer: advance the pointer past the winner and release the lock;
  //   - stall: capture the grant;
  //   - locked requester vanishes: drop the lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        prio[i] <= '0;
        lsel[i] <= '0;
      end
      lock <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (outValid[i] && bus.umi_out_ready[i]) begin
          prio[i] <= nextPrio[i];
          lock[i] <= 1'b0;
        end else if (outValid[i]) begin
          lock[i] <= 1'b1;
          lsel[i] <= selC[i*N +: N];
        end else if (lock[i]) begin
          lock[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_umi_crossbar_arbiter.sv
// Directed testbench for umi_crossbar_arbiter with N = 4. It covers:
//   - round-robin rotation and lock hold under backpressure;
//   - lock drop, all-outputs parallel transfer and masking;
//   - request filtering and reset in the middle of a lock.
module tb_umi_crossbar_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  umi_crossbar_arbiter_if #(.N(N)) bus ();

  umi_crossbar_arbiter #(.TARGET("DEFAULT"), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Each output group of sel may have at most one bit set, checked every cycle.
  always begin
    @(negedge clk);
    #3;
    for (int i = 0; i < N; i++) begin
      assertCount++;
      if (!$onehot0(bus.sel[i*N +: N])) begin
        failCount++;
        $display("[TB] FAIL sel_onehot out%0d: got %b required at most one bit", i, bus.sel[i*N +: N]);
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N*N-1:0] r,
                       input logic [N*N-1:0] m, input logic [N-1:0] ordy);
    bus.umi_in_valid  = v;
    bus.umi_in_req    = r;
    bus.mask          = m;
    bus.umi_out_ready = ordy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive('0, '0, '1, '0);
    @(negedge clk);
    @(negedge clk);
    #1;
    assertCount++;
    if (bus.sel !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_sel: got %h required %h", bus.sel, 16'h0000); end
    assertCount++;
    if (bus.umi_out_valid !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b required %b", bus.umi_out_valid, 4'b0000); end
    assertCount++;
    if (bus.umi_in_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b required %b", bus.umi_in_ready, 4'b0000); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    assertCount++;
    if (bus.sel !== 16'h0000) begin failCount++; $display("[TB] FAIL idle_sel: got %h required %h", bus.sel, 16'h0000); end
  endtask

  task automatic test_round_robin;
    logic [3:0] expSel [5];
    expSel[0] = 4'b0001; expSel[1] = 4'b0010; expSel[2] = 4'b0100;
    expSel[3] = 4'b1000; expSel[4] = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(4'b1111, 16'h000F, '1, 4'b0001);
      #1;
      assertCount++;
      if (bus.sel[3:0] !== expSel[c]) begin failCount++; $display("[TB] FAIL rr_sel cycle%0d: got %b required %b", c, bus.sel[3:0], expSel[c]); end
      assertCount++;
      if (bus.umi_in_ready !== expSel[c]) begin failCount++; $display("[TB] FAIL rr_in_ready cycle%0d: got %b required %b", c, bus.umi_in_ready, expSel[c]); end
      assertCount++;
      if (bus.umi_out_valid !== 4'b0001) begin failCount++; $display("[TB] FAIL rr_out_valid cycle%0d: got %b required %b", c, bus.umi_out_valid, 4'b0001); end
    end
  endtask

  task automatic test_lock;
    @(negedge clk);
    drive(4'b0100, 16'h0050, '1, 4'b0000);
    #1;
    assertCount++;
    if (bus.sel[7:4] !== 4'b0100) begin failCount++; $display("[TB] FAIL lock_first_sel: got %b required %b", bus.sel[7:4], 4'b0100); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(4'b0101, 16'h0050, '1, 4'b0000);
      #1;
      assertCount++;
      if (bus.sel[7:4] !== 4'b0100) begin failCount++; $display("[TB] FAIL lock_hold_sel cycle%0d: got %b required %b", c, bus.sel[7:4], 4'b0100); end
      assertCount++;
      if (bus.umi_out_valid !== 4'b0010) begin failCount++; $display("[TB] FAIL lock_hold_valid cycle%0d: got %b required %b", c, bus.umi_out_valid, 4'b0010); end
      assertCount++;
      if (bus.umi_in_ready !== 4'b0000) begin failCount++; $display("[TB] FAIL lock_hold_ready cycle%0d: got %b required %b", c, bus.umi_in_ready, 4'b0000); end
    end
    @(negedge clk);
    drive(4'b0101, 16'h0050, '1, 4'b0010);
    #1;
    assertCount++;
    if (bus.sel[7:4] !== 4'b0100) begin failCount++; $display("[TB] FAIL lock_release_sel: got %b required %b", bus.sel[7:4], 4'b0100); end
    assertCount++;
    if (bus.umi_in_ready !== 4'b0100) begin failCount++; $display("[TB] FAIL lock_release_ready: got %b required %b", bus.umi_in_ready, 4'b0100); end
    @(negedge clk);
    #1;
    assertCount++;
    if (bus.sel[7:4] !== 4'b0001) begin failCount++; $display("[TB] FAIL lock_next_sel: got %b required %b", bus.sel[7:4], 4'b0001); end
    assertCount++;
    if (bus.umi_in_ready !== 4'b0001) begin failCount++; $display("[TB] FAIL lock_next_ready: got %b required %b", bus.umi_in_ready, 4'b0001); end
  endtask

  task automatic test_lock_drop;
    @(negedge clk);
    drive(4'b0010, 16'h0200, '1, 4'b0000);
    #1;
    assertCount++;
    if (bus.sel !== 16'h0200) begin failCount++; $display("[TB] FAIL drop_grant_sel: got %h required %h", bus.sel, 16'h0200); end
    assertCount++;
    if (bus.umi_out_valid !== 4'b0100) begin failCount++; $display("[TB] FAIL drop_grant_valid: got %b required %b", bus.umi_out_valid, 4'b0100); end
    @(negedge clk);
    drive(4'b0000, 16'h0200, '1, 4'b0000);
    #1;
    assertCount++;
    if (bus.sel !== 16'h0200) begin failCount++; $display("[TB] FAIL drop_held_sel: got %h required %h", bus.sel, 16'h0200); end
    assertCount++;
    if (bus.umi_out_valid !== 4'b0000) begin failCount++; $display("[TB] FAIL drop_valid: got %b required %b", bus.umi_out_valid, 4'b0000); end
    @(negedge clk);
    #1;
    assertCount++;
    if (bus.sel !== 16'h0000) begin failCount++; $display("[TB] FAIL drop_after_sel: got %h required %h", bus.sel, 16'h0000); end
  endtask

  task automatic test_back_to_back_all_outputs;
    @(negedge clk);
    drive(4'b1111, 16'h1248, '1, 4'b1111);
    #1;
    assertCount++;
    if (bus.sel !== 16'h1248) begin failCount++; $display("[TB] FAIL all_sel: got %h required %h", bus.sel, 16'h1248); end
    assertCount++;
    if (bus.umi_out_valid !== 4'b1111) begin failCount++; $display("[TB] FAIL all_out_valid: got %b required %b", bus.umi_out_valid, 4'b1111); end
    assertCount++;
    if (bus.umi_in_ready !== 4'b1111) begin failCount++; $display("[TB] FAIL all_in_ready: got %b required %b", bus.umi_in_ready, 4'b1111); end
  endtask

  task automatic test_mask;
    @(negedge clk);
    drive(4'b0010, 16'h0002, 16'hFFFD, 4'b0001);
    #1;
    assertCount++;
    if (bus.umi_out_valid[0] !== 1'b0) begin failCount++; $display("[TB] FAIL mask_out_valid: got %b required %b", bus.umi_out_valid[0], 1'b0); end
    assertCount++;
    if (bus.sel[3:0] !== 4'b0000) begin failCount++; $display("[TB] FAIL mask_sel: got %b required %b", bus.sel[3:0], 4'b0000); end
    assertCount++;
    if (bus.umi_in_ready[1] !== 1'b0) begin failCount++; $display("[TB] FAIL mask_in_ready: got %b required %b", bus.umi_in_ready[1], 1'b0); end
    bus.mask = 16'hFFFF;
    #1;
    assertCount++;
    if (bus.sel !== 16'h0002) begin failCount++; $display("[TB] FAIL unmask_sel: got %h required %h", bus.sel, 16'h0002); end
    assertCount++;
    if (bus.umi_in_ready !== 4'b0010) begin failCount++; $display("[TB] FAIL unmask_in_ready: got %b required %b", bus.umi_in_ready, 4'b0010); end
  endtask

  task automatic test_filter;
    @(negedge clk);
    drive(4'b1000, 16'h0880, '1, 4'b1111);
    #1;
    assertCount++;
    if (bus.sel[7] !== 1'b1) begin failCount++; $display("[TB] FAIL filter_sel_out1: got %b required %b", bus.sel[7], 1'b1); end
    assertCount++;
    if (bus.sel[11] !== 1'b0) begin failCount++; $display("[TB] FAIL filter_sel_out2: got %b required %b", bus.sel[11], 1'b0); end
    assertCount++;
    if (bus.umi_out_valid !== 4'b0010) begin failCount++; $display("[TB] FAIL filter_out_valid: got %b required %b", bus.umi_out_valid, 4'b0010); end
    assertCount++;
    if (bus.umi_in_ready !== 4'b1000) begin failCount++; $display("[TB] FAIL filter_in_ready: got %b required %b", bus.umi_in_ready, 4'b1000); end
  endtask

  task automatic test_reset_mid_lock;
    @(negedge clk);
    drive(4'b0010, 16'h0002, '1, 4'b0000);
    #1;
    assertCount++;
    if (bus.sel[3:0] !== 4'b0010) begin failCount++; $display("[TB] FAIL rlock_grant_sel: got %b required %b", bus.sel[3:0], 4'b0010); end
    @(negedge clk);
    drive(4'b0011, 16'h0003, '1, 4'b0000);
    #1;
    assertCount++;
    if (bus.sel[3:0] !== 4'b0010) begin failCount++; $display("[TB] FAIL rlock_hold_sel: got %b required %b", bus.sel[3:0], 4'b0010); end
    #1;
    reset = 1'b1;
    #1;
    assertCount++;
    if (bus.sel[3:0] !== 4'b0001) begin failCount++; $display("[TB] FAIL rlock_in_reset_sel: got %b required %b", bus.sel[3:0], 4'b0001); end
    @(negedge clk);
    reset = 1'b0;
    bus.umi_out_ready = 4'b0001;
    #1;
    assertCount++;
    if (bus.sel[3:0] !== 4'b0001) begin failCount++; $display("[TB] FAIL rlock_after_sel: got %b required %b", bus.sel[3:0], 4'b0001); end
    assertCount++;
    if (bus.umi_in_ready !== 4'b0001) begin failCount++; $display("[TB] FAIL rlock_after_ready: got %b required %b", bus.umi_in_ready, 4'b0001); end
    assertCount++;
    if (bus.umi_out_valid !== 4'b0001) begin failCount++; $display("[TB] FAIL rlock_after_valid: got %b required %b", bus.umi_out_valid, 4'b0001); end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting umi_crossbar_arbiter directed tests");
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_back_to_back_all_outputs();
    test_mask();
    test_filter();
    test_reset_mid_lock();
    @(negedge clk);
    drive('0, '0, '1, '0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
